// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// Byte-serial scheduler for the shared memory port: fetch vs load/store, first byte one cycle after grant, registered done pulse.
// Requesters hold their inputs until done; IO stores stall while io_buffer_full is high and leave a gap cycle after every byte.
module mem_port_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [2:0]        d_len,
    input  logic              d_signed,
    input  logic [31:0]       d_wdata,
    output logic              d_done,
    output logic [31:0]       d_rdata,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [31:0]       mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full,
    output logic              busy
);

    typedef enum logic [2:0] {IDLE, RD, RD_LAST, WR, IO_GAP} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] base;
    logic [2:0]        nbytes, idx;
    logic              is_fetch, sgn;
    logic [31:0]       wbuf, rbuf;
    logic [1:0]        streak;

    logic              f_ok, d_ok, grant_f, grant_d;
    logic [2:0]        d_nbytes;
    logic [ADDR_W-1:0] cur_a;
    logic              io_byte, io_stall, last_byte;
    logic [1:0]        cap_lane;
    logic [31:0]       rd_word, ld_ext;

    // A requester whose done pulse is up is still showing its stale request.
    assign f_ok      = if_req & ~if_done;
    assign d_ok      = d_req & ~d_done;
    assign grant_f   = (state == IDLE) & f_ok & (~d_ok | (streak >= 2'd2));
    assign grant_d   = (state == IDLE) & d_ok & ~grant_f;
    assign d_nbytes  = (d_len == 3'd1) ? 3'd1 : (d_len == 3'd2) ? 3'd2 : 3'd4;
    assign cur_a     = base + ADDR_W'(idx);
    assign io_byte   = (cur_a[17:16] == 2'b11);
    assign io_stall  = (state == WR) & io_byte & io_buffer_full;
    assign last_byte = (idx == nbytes - 3'd1);
    assign busy      = (state != IDLE);

    // Read data arrives one cycle behind its address, so RD captures the previous lane.
    always_comb begin
        cap_lane = (state == RD_LAST) ? 2'(nbytes - 3'd1) : 2'(idx - 3'd1);
        rd_word  = rbuf;
        rd_word[{cap_lane, 3'b000} +: 8] = mem_din;
        ld_ext   = rd_word;
        if (nbytes == 3'd1)
            ld_ext = {{24{sgn & rd_word[7]}}, rd_word[7:0]};
        else if (nbytes == 3'd2)
            ld_ext = {{16{sgn & rd_word[15]}}, rd_word[15:0]};
    end

    always_comb begin
        mem_a    = '0;
        mem_dout = '0;
        mem_wr   = 1'b0;
        if (state == RD) begin
            mem_a = 32'(cur_a);
        end else if (state == WR && !io_stall) begin
            mem_a    = 32'(cur_a);
            mem_dout = 8'(wbuf >> {idx, 3'b000});
            mem_wr   = 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (grant_f || (grant_d && !d_we))
                    state_nx = RD;
                else if (grant_d)
                    state_nx = WR;
            end
            RD:      if (last_byte) state_nx = RD_LAST;
            RD_LAST: state_nx = IDLE;
            WR: begin
                if (io_byte) begin
                    if (!io_buffer_full)
                        state_nx = IO_GAP;
                end else if (last_byte) begin
                    state_nx = IDLE;
                end
            end
            IO_GAP:  state_nx = last_byte ? IDLE : WR;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            base     <= '0;
            nbytes   <= '0;
            idx      <= '0;
            is_fetch <= 1'b0;
            sgn      <= 1'b0;
            wbuf     <= '0;
            rbuf     <= '0;
            streak   <= '0;
            if_done  <= 1'b0;
            if_data  <= '0;
            d_done   <= 1'b0;
            d_rdata  <= '0;
        end else begin
            state   <= state_nx;
            if_done <= 1'b0;
            d_done  <= 1'b0;
            if_data <= '0;
            d_rdata <= '0;
            if (grant_f || grant_d) begin
                base     <= grant_f ? if_addr : d_addr;
                nbytes   <= grant_f ? 3'd4 : d_nbytes;
                is_fetch <= grant_f;
                sgn      <= grant_d & d_signed;
                wbuf     <= d_wdata;
                rbuf     <= '0;
                idx      <= '0;
                if (grant_f)
                    streak <= '0;
                else if (if_req && streak != 2'd3)
                    streak <= streak + 2'd1;
            end
            case (state)
                RD: begin
                    if (idx != 3'd0)
                        rbuf <= rd_word;
                    idx <= idx + 3'd1;
                end
                RD_LAST: begin
                    if (is_fetch) begin
                        if_done <= 1'b1;
                        if_data <= rd_word;
                    end else begin
                        d_done  <= 1'b1;
                        d_rdata <= ld_ext;
                    end
                end
                WR: begin
                    if (!io_byte) begin
                        idx <= idx + 3'd1;
                        if (last_byte)
                            d_done <= 1'b1;
                    end
                end
                IO_GAP: begin
                    idx <= idx + 3'd1;
                    if (last_byte)
                        d_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// Bench for mem_port_arbiter: a beat-list reference model checked every cycle, plus directed scenarios with literal expectations.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_done;
    logic [31:0] if_addr, if_data;
    logic        d_req, d_we, d_signed, d_done;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [2:0]  d_len;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr, io_buffer_full, busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_len(d_len), .d_signed(d_signed),
        .d_wdata(d_wdata), .d_done(d_done), .d_rdata(d_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full), .busy(busy)
    );

    task automatic check1(input string nm, input logic act, input logic want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %b want %b (t=%0t)", nm, act, want, $time);
        end
    endtask

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: each transaction becomes a list of bus beats; done follows the last beat.
    localparam logic [1:0] B_RD = 2'd0, B_CAP = 2'd1, B_WR = 2'd2, B_GAP = 2'd3;
    typedef struct packed {
        logic [1:0]  kind;
        logic        io;
        logic [31:0] a;
        logic [7:0]  d;
    } beat_t;

    beat_t       q[$];
    logic [7:0]  bmem [0:4095];
    logic [31:0] pend_a = 32'd0;
    logic        m_if_done = 1'b0, m_d_done = 1'b0, m_cur_f = 1'b0;
    logic [31:0] m_val = 32'd0, m_if_data = 32'd0, m_d_rdata = 32'd0;
    int          m_streak = 0;
    string       glog = "";
    logic        n_if, n_d, f_ok, d_ok, e_wr;
    logic [31:0] e_a;
    logic [7:0]  e_d;

    task automatic grant(input logic f, input logic [31:0] base, input int n,
                         input logic we, input logic sg, input logic [31:0] wd);
        beat_t b;
        logic [31:0] v;
        v = 32'd0;
        m_cur_f = f;
        for (int i = 0; i < n; i++) begin
            b.a  = base + 32'(i);
            b.io = (b.a[17:16] == 2'b11);
            b.d  = we ? wd[8*i +: 8] : 8'd0;
            b.kind = we ? B_WR : B_RD;
            q.push_back(b);
            if (we && b.io) begin
                b.kind = B_GAP;
                q.push_back(b);
            end
            if (!we)
                v = v | (32'(bmem[b.a[11:0]]) << (8*i));
        end
        if (!we) begin
            b.kind = B_CAP;
            q.push_back(b);
        end
        if (!we && n < 4 && sg && v[8*n-1])
            v = v | (32'hFFFF_FFFF << (8*n));
        m_val = we ? 32'd0 : v;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            m_if_done = 1'b0;
            m_d_done  = 1'b0;
            m_streak  = 0;
        end else begin
            e_a = 32'd0; e_d = 8'd0; e_wr = 1'b0;
            if (q.size() > 0) begin
                if (q[0].kind == B_RD) begin
                    e_a = q[0].a;
                end else if (q[0].kind == B_WR && !(q[0].io && io_buffer_full)) begin
                    e_a = q[0].a; e_d = q[0].d; e_wr = 1'b1;
                end
            end
            check1("busy", busy, q.size() > 0);
            check1("if_done", if_done, m_if_done);
            check1("d_done", d_done, m_d_done);
            check32("mem_a", mem_a, e_a);
            check32("mem_dout", {24'd0, mem_dout}, {24'd0, e_d});
            check1("mem_wr", mem_wr, e_wr);
            if (m_if_done) check32("if_data", if_data, m_if_data);
            if (m_d_done)  check32("d_rdata", d_rdata, m_d_rdata);

            if (mem_wr) bmem[mem_a[11:0]] = mem_dout;
            pend_a = mem_a;

            n_if = 1'b0; n_d = 1'b0;
            if (q.size() > 0) begin
                if (!(q[0].kind == B_WR && q[0].io && io_buffer_full)) begin
                    void'(q.pop_front());
                    if (q.size() == 0) begin
                        if (m_cur_f) begin n_if = 1'b1; m_if_data = m_val; end
                        else begin n_d = 1'b1; m_d_rdata = m_val; end
                    end
                end
            end else begin
                f_ok = if_req && !m_if_done;
                d_ok = d_req && !m_d_done;
                if (f_ok && (!d_ok || m_streak >= 2)) begin
                    grant(1'b1, if_addr, 4, 1'b0, 1'b0, 32'd0);
                    glog = {glog, "F"};
                    m_streak = 0;
                end else if (d_ok) begin
                    grant(1'b0, d_addr, int'(d_len), d_we, d_signed, d_wdata);
                    glog = {glog, "D"};
                    if (if_req) m_streak++;
                end
            end
            m_if_done = n_if;
            m_d_done  = n_d;
        end
    end

    // Memory responder: data for an address appears in the following cycle.
    initial forever begin
        @(posedge clk);
        #1;
        mem_din = bmem[pend_a[11:0]];
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_load(input string nm, input logic [31:0] a, input logic [2:0] len,
                           input logic sg, input logic [31:0] want);
        logic seen;
        seen = 1'b0;
        d_we = 1'b0; d_addr = a; d_len = len; d_signed = sg; d_req = 1'b1;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            if (d_done) begin
                seen = 1'b1;
                check32(nm, d_rdata, want);
            end
        end
        d_req = 1'b0;
        if (!seen) begin
            total++; bad++;
            $display("FAIL %s: no d_done within 20 cycles", nm);
        end
        tick();
    endtask

    logic [7:0] t5b [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};

    initial begin
        logic ok;
        for (int i = 0; i < 4096; i++) bmem[i] = 8'(i * 7 + 3);
        bmem[12'h100] = 8'h13; bmem[12'h101] = 8'h05; bmem[12'h102] = 8'h50; bmem[12'h103] = 8'h00;
        bmem[12'h140] = 8'h80; bmem[12'h180] = 8'h01; bmem[12'h181] = 8'h80;
        rst = 1'b1; if_req = 1'b0; if_addr = 32'd0; d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0;
        d_len = 3'd1; d_signed = 1'b0; d_wdata = 32'd0; io_buffer_full = 1'b0; mem_din = 8'd0;

        #2;
        check1("rst_if_done", if_done, 1'b0);
        check1("rst_d_done", d_done, 1'b0);
        check32("rst_if_data", if_data, 32'd0);
        check32("rst_d_rdata", d_rdata, 32'd0);
        check32("rst_mem_a", mem_a, 32'd0);
        check32("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
        check1("rst_mem_wr", mem_wr, 1'b0);
        check1("rst_busy", busy, 1'b0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Fetch only
        if_addr = 32'h100; if_req = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k <= 4) check32("t1_mem_a", mem_a, 32'h100 + 32'(k - 1));
            if (k == 5) check1("t1_early_done", if_done, 1'b0);
            if (k == 6) begin
                check1("t1_if_done", if_done, 1'b1);
                check32("t1_if_data", if_data, 32'h0050_0513);
            end
            if (if_done) if_req = 1'b0;
        end
        if_req = 1'b0;
        tick();

        // Simultaneous requests: data first, fetch granted in the d_done cycle
        d_we = 1'b0; d_addr = 32'h140; d_len = 3'd1; d_signed = 1'b1; d_req = 1'b1;
        if_addr = 32'h100; if_req = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 3) begin
                check1("t2_d_done", d_done, 1'b1);
                check32("t2_d_rdata", d_rdata, 32'hFFFF_FF80);
            end
            if (k == 4) check32("t2_fetch_starts", mem_a, 32'h100);
            if (k == 9) begin
                check1("t2_if_done", if_done, 1'b1);
                check32("t2_if_data", if_data, 32'h0050_0513);
            end
            if (d_done) d_req = 1'b0;
            if (if_done) if_req = 1'b0;
        end
        d_req = 1'b0; if_req = 1'b0;
        tick();

        // Data requests back to back; fetch withdraws while data's done pulse is up
        glog = "";
        d_we = 1'b0; d_addr = 32'h180; d_len = 3'd2; d_signed = 1'b0; d_req = 1'b1;
        if_addr = 32'h100; if_req = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (d_done) check32("t3_d_rdata", d_rdata, 32'h0000_8001);
            if (glog.len() >= 6) begin
                d_req = 1'b0;
                if (if_done) begin
                    ok = 1'b1;
                    break;
                end
            end else begin
                if_req = !d_done;
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL t3_timeout: grant log %s after 200 cycles, want DDFDDF", glog);
        end
        total++;
        if (glog != "DDFDDF") begin
            bad++;
            $display("FAIL t3_grants: got %s want DDFDDF", glog);
        end
        tick();

        // IO store stalled by a full UART buffer
        d_we = 1'b1; d_addr = 32'h0003_0000; d_len = 3'd1; d_wdata = 32'h41;
        io_buffer_full = 1'b1; d_req = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 4) begin
                io_buffer_full = 1'b0;
                #1;
            end
            if (k <= 3) check1("t4_stall_wr", mem_wr, 1'b0);
            if (k == 4) begin
                check1("t4_wr", mem_wr, 1'b1);
                check32("t4_dout", {24'd0, mem_dout}, 32'h41);
                check32("t4_addr", mem_a, 32'h0003_0000);
            end
            if (k == 5) begin
                check1("t4_gap_wr", mem_wr, 1'b0);
                check1("t4_gap_nodone", d_done, 1'b0);
            end
            if (k == 6) begin
                check1("t4_d_done", d_done, 1'b1);
                check32("t4_d_rdata", d_rdata, 32'd0);
            end
            if (d_done) d_req = 1'b0;
        end
        d_req = 1'b0;
        tick();

        // Word store to plain memory; full flag must be ignored
        d_we = 1'b1; d_addr = 32'h200; d_len = 3'd4; d_wdata = 32'hDEAD_BEEF;
        io_buffer_full = 1'b1; d_req = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k <= 4) begin
                check32("t5_addr", mem_a, 32'h200 + 32'(k - 1));
                check32("t5_dout", {24'd0, mem_dout}, {24'd0, t5b[k-1]});
                check1("t5_wr", mem_wr, 1'b1);
            end
            if (k == 5) check1("t5_d_done", d_done, 1'b1);
            if (d_done) d_req = 1'b0;
        end
        d_req = 1'b0; io_buffer_full = 1'b0;
        tick();

        // Extension boundaries
        do_load("t_ld_h_signed", 32'h180, 3'd2, 1'b1, 32'hFFFF_8001);
        do_load("t_ld_b_unsigned", 32'h140, 3'd1, 1'b0, 32'h0000_0080);
        do_load("t_ld_w_pass", 32'h100, 3'd4, 1'b1, 32'h0050_0513);

        // Reset in the middle of a fetch
        if_addr = 32'h100; if_req = 1'b1;
        for (int k = 1; k <= 3; k++) tick();
        check32("t6_byte2", mem_a, 32'h102);
        #2;
        rst = 1'b1;
        #1;
        check32("t6_rst_mem_a", mem_a, 32'd0);
        check1("t6_rst_mem_wr", mem_wr, 1'b0);
        check1("t6_rst_busy", busy, 1'b0);
        check1("t6_rst_if_done", if_done, 1'b0);
        if_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check1("t6_no_done_in_rst", if_done, 1'b0);
        end
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check1("t6_no_done_after", if_done, 1'b0);
        end
        if_req = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 1) check32("t6_refetch_a", mem_a, 32'h100);
            if (k == 6) begin
                check1("t6_if_done", if_done, 1'b1);
                check32("t6_if_data", if_data, 32'h0050_0513);
            end
            if (if_done) if_req = 1'b0;
        end
        if_req = 1'b0;
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
